// File: rtl/mem_access_pkg.sv
// Shared types and codes for the memory access controller.
// Optional feature macro: MEM_MISALIGN_SPLIT_EN (two-beat misaligned access).
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BEAT1,
    BEAT2,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_t;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_BYTE = 2'b11;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LB  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  localparam int BUS_TIMEOUT_DEF = 16;

  // Store size wins over load type; unknown load codes act as lw
  function automatic acc_size_t size_of(
    input logic [1:0] mw,
    input logic [2:0] sl
  );
    size_of = SZ_WORD;
    if (mw != MW_NONE) begin
      unique case (mw)
        MW_HALF: size_of = SZ_HALF;
        MW_BYTE: size_of = SZ_BYTE;
        default: size_of = SZ_WORD;
      endcase
    end else begin
      unique case (sl)
        LD_LH, LD_LHU: size_of = SZ_HALF;
        LD_LB, LD_LBU: size_of = SZ_BYTE;
        default:       size_of = SZ_WORD;
      endcase
    end
  endfunction

endpackage

// File: rtl/mem_align.sv
// Lane mask, write data positioning and load extraction/extension.
// Purely combinational; shared by both beats of an access.
module mem_align
  import mem_access_pkg::*;
(
  input  acc_size_t   sz,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  output logic [7:0]  be64,
  output logic [63:0] wd64,
  output logic        split,
  input  logic [2:0]  lt,
  input  logic [1:0]  ld_lo,
  input  logic [63:0] rword,
  output logic [31:0] ldata
);

  logic [3:0]  mask;
  logic [31:0] w;

  always_comb begin
    mask = 4'b1111;
    unique case (sz)
      SZ_BYTE: mask = 4'b0001;
      SZ_HALF: mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    be64  = {4'b0000, mask} << lo;
    wd64  = {32'h0, wdata} << {lo, 3'b000};
    split = |be64[7:4];

    w = rword[{ld_lo, 3'b000} +: 32];
    unique case (lt)
      LD_LH:   ldata = {{16{w[15]}}, w[15:0]};
      LD_LHU:  ldata = {16'h0, w[15:0]};
      LD_LB:   ldata = {{24{w[7]}}, w[7:0]};
      LD_LBU:  ldata = {24'h0, w[7:0]};
      default: ldata = w;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Core-to-bus load/store controller with per-beat bus timeout.
// Define MEM_MISALIGN_SPLIT_EN to split misaligned accesses into two beats.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        LoadOp,
  input  logic [1:0]  MemWrite,
  input  logic [2:0]  SizeLoad,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int TW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(BUS_TIMEOUT - 1);

  state_t      state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic        req_ready_n, rsp_valid_n, fault_n;
  logic [31:0] rdata_n;
  logic        bus_req_n, bus_we_n;
  logic [31:0] bus_addr_n, bus_wdata_n;
  logic [3:0]  bus_be_n;
  logic [3:0]  hi_be, hi_be_n;
  logic [31:0] hi_wd, hi_wd_n;
  logic        split_q, split_n;
  logic        ld_q, ld_n;
  logic [2:0]  lt_q, lt_n;
  logic [1:0]  lo_q, lo_n;
  logic [31:0] beat1_q, beat1_n;

  logic        is_st, is_ld, split;
  logic [7:0]  be64;
  logic [63:0] wd64, rword;
  logic [31:0] ldata;

  assign is_st = (MemWrite != MW_NONE);
  assign is_ld = !is_st && LoadOp;
  assign rword = (state == BEAT2) ? {bus_rdata, beat1_q}
                                  : {32'h0, bus_rdata};

  mem_align u_align (
    .sz    (size_of(MemWrite, SizeLoad)),
    .lo    (addr[1:0]),
    .wdata (wdata),
    .be64  (be64),
    .wd64  (wd64),
    .split (split),
    .lt    (lt_q),
    .ld_lo (lo_q),
    .rword (rword),
    .ldata (ldata)
  );

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    rsp_valid_n = 1'b0;
    rdata_n     = rdata;
    fault_n     = fault;
    bus_req_n   = bus_req;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_be_n    = bus_be;
    bus_wdata_n = bus_wdata;
    hi_be_n     = hi_be;
    hi_wd_n     = hi_wd;
    split_n     = split_q;
    ld_n        = ld_q;
    lt_n        = lt_q;
    lo_n        = lo_q;
    beat1_n     = beat1_q;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          ld_n    = is_ld;
          lt_n    = SizeLoad;
          lo_n    = addr[1:0];
          split_n = split;
          if (!is_st && !is_ld) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rdata_n     = 32'h0;
            fault_n     = 1'b0;
          end
`ifndef MEM_MISALIGN_SPLIT_EN
          else if (split) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rdata_n     = 32'h0;
            fault_n     = 1'b1;
          end
`endif
          else begin
            state_n     = BEAT1;
            timer_n     = '0;
            bus_req_n   = 1'b1;
            bus_we_n    = is_st;
            bus_addr_n  = {addr[31:2], 2'b00};
            bus_be_n    = be64[3:0];
            bus_wdata_n = wd64[31:0];
            hi_be_n     = be64[7:4];
            hi_wd_n     = wd64[63:32];
          end
        end
      end
      BEAT1, BEAT2: begin
        if (bus_ack) begin
          timer_n = '0;
          if (state == BEAT1 && split_q) begin
            state_n     = BEAT2;
            beat1_n     = bus_rdata;
            bus_addr_n  = bus_addr + 32'd4;
            bus_be_n    = hi_be;
            bus_wdata_n = hi_wd;
          end else begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            bus_req_n   = 1'b0;
            bus_we_n    = 1'b0;
            fault_n     = 1'b0;
            rdata_n     = ld_q ? ldata : 32'h0;
          end
        end else if (timer == TMAX) begin
          // give up on this beat and any beat still pending
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          bus_req_n   = 1'b0;
          bus_we_n    = 1'b0;
          fault_n     = 1'b1;
          rdata_n     = 32'h0;
          timer_n     = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    req_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rdata     <= 32'h0;
      fault     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      hi_be     <= 4'h0;
      hi_wd     <= 32'h0;
      split_q   <= 1'b0;
      ld_q      <= 1'b0;
      lt_q      <= 3'h0;
      lo_q      <= 2'h0;
      beat1_q   <= 32'h0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rdata     <= rdata_n;
      fault     <= fault_n;
      bus_req   <= bus_req_n;
      bus_we    <= bus_we_n;
      bus_addr  <= bus_addr_n;
      bus_be    <= bus_be_n;
      bus_wdata <= bus_wdata_n;
      hi_be     <= hi_be_n;
      hi_wd     <= hi_wd_n;
      split_q   <= split_n;
      ld_q      <= ld_n;
      lt_q      <= lt_n;
      lo_q      <= lo_n;
      beat1_q   <= beat1_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and random checks of mem_access_ctrl against a byte-level model.
module tb_mem_access_ctrl;

`ifdef MEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        LoadOp;
  logic [1:0]  MemWrite;
  logic [2:0]  SizeLoad;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.BUS_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .LoadOp    (LoadOp),
    .MemWrite  (MemWrite),
    .SizeLoad  (SizeLoad),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .fault     (fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one access, play the bus slave, and check against the model
  task automatic run(input string tag, input logic [1:0] mw,
                     input logic lop, input logic [2:0] sl,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input int d1, input int d2, input bit noack);
    bit          isst, isld, mis;
    int          nb, lo, nbeats, explat, cyc, beat, waitc, reqcyc;
    bit          got;
    logic [63:0] m64, d64, v64, dmask;
    logic [31:0] ba [2];
    logic [3:0]  bb [2];
    logic [31:0] bw [2];
    logic [31:0] rr [2];
    int          dl [2];
    logic [31:0] erd, v;
    logic        efault;

    isst = (mw != 2'b00);
    isld = !isst && lop;
    if (isst) nb = (mw == 2'b01) ? 4 : (mw == 2'b10) ? 2 : 1;
    else nb = (sl == 3'd1 || sl == 3'd4) ? 2 :
              (sl == 3'd2 || sl == 3'd3) ? 1 : 4;
    lo  = int'(a[1:0]);
    mis = (nb == 4 && lo != 0) || (nb == 2 && lo == 3);
    m64 = ((64'd1 << nb) - 64'd1) << lo;
    d64 = {32'h0, wd} << (8 * lo);
    ba[0] = {a[31:2], 2'b00};
    ba[1] = ba[0] + 32'd4;
    bb[0] = m64[3:0];
    bb[1] = m64[7:4];
    bw[0] = d64[31:0];
    bw[1] = d64[63:32];
    rr[0] = r1;
    rr[1] = r2;
    dl[0] = d1;
    dl[1] = d2;
    if (!isst && !isld) nbeats = 0;
    else if (mis) nbeats = SPLIT_EN ? 2 : 0;
    else nbeats = 1;
    efault = ((isst || isld) && mis && !SPLIT_EN) || (noack && nbeats > 0);
    erd = 32'h0;
    if (isld && !efault) begin
      v64   = {(nbeats == 2) ? r2 : 32'h0, r1} >> (8 * lo);
      dmask = (64'd1 << (8 * nb)) - 64'd1;
      v     = v64[31:0] & dmask[31:0];
      if ((sl == 3'd1 || sl == 3'd2) && v[8 * nb - 1]) v = v | ~dmask[31:0];
      erd = v;
    end
    if (nbeats == 0) explat = 0;
    else if (noack) explat = TMO;
    else explat = d1 + 1 + ((nbeats == 2) ? d2 + 1 : 0);

    req_valid = 1'b1;
    MemWrite  = mw;
    LoadOp    = lop;
    SizeLoad  = sl;
    addr      = a;
    wdata     = wd;
    chk({tag, ".req_ready"}, {31'h0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    addr      = $urandom;
    wdata     = $urandom;

    cyc = 0; beat = 0; waitc = 0; reqcyc = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (rsp_valid) begin
        got = 1'b1;
        chk({tag, ".rdata"}, rdata, erd);
        chk({tag, ".fault"}, {31'h0, fault}, {31'h0, efault});
        chk({tag, ".latency"}, 32'(cyc), 32'(explat));
        chk({tag, ".reqcyc"}, 32'(reqcyc), 32'(explat));
        chk({tag, ".beats"}, 32'(beat), 32'(noack ? 0 : nbeats));
      end else if (bus_req) begin
        reqcyc++;
        if (beat >= nbeats) begin
          chk({tag, ".extra_beat"}, 32'(beat), 32'(nbeats));
        end else begin
          if (waitc == 0) begin
            chk({tag, ".bus_addr"}, bus_addr, ba[beat]);
            chk({tag, ".bus_be"}, {28'h0, bus_be}, {28'h0, bb[beat]});
            chk({tag, ".bus_we"}, {31'h0, bus_we}, {31'h0, isst});
            if (isst) chk({tag, ".bus_wdata"}, bus_wdata, bw[beat]);
          end
          if (!noack && waitc == dl[beat]) begin
            bus_ack   = 1'b1;
            bus_rdata = rr[beat];
            beat++;
            waitc = 0;
          end else begin
            waitc++;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus_ack = 1'b0;
    chk({tag, ".rsp_seen"}, {31'h0, got}, 32'd1);
    chk({tag, ".rsp_pulse"}, {31'h0, rsp_valid}, 32'd0);
    chk({tag, ".ready_after"}, {31'h0, req_ready}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    LoadOp    = 1'b0;
    MemWrite  = 2'b00;
    SizeLoad  = 3'd0;
    addr      = 32'h0;
    wdata     = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    repeat (3) @(negedge clk);

    chk("rst.req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst.fault", {31'h0, fault}, 32'd0);
    chk("rst.bus_req", {31'h0, bus_req}, 32'd0);
    chk("rst.bus_we", {31'h0, bus_we}, 32'd0);
    chk("rst.bus_addr", bus_addr, 32'h0);
    chk("rst.bus_be", {28'h0, bus_be}, 32'h0);
    chk("rst.bus_wdata", bus_wdata, 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run("lw", 2'b00, 1'b1, 3'd0, 32'h100, 32'h0,
        32'hDEADBEEF, 32'h0, 2, 0, 1'b0);
    run("lb", 2'b00, 1'b1, 3'd2, 32'h103, 32'h0,
        32'h80123456, 32'h0, 1, 0, 1'b0);
    run("lbu", 2'b00, 1'b1, 3'd3, 32'h103, 32'h0,
        32'h80123456, 32'h0, 0, 0, 1'b0);
    run("lh", 2'b00, 1'b1, 3'd1, 32'h102, 32'h0,
        32'h9abc0000, 32'h0, 0, 0, 1'b0);
    run("lhu", 2'b00, 1'b1, 3'd4, 32'h102, 32'h0,
        32'h9abc0000, 32'h0, 3, 0, 1'b0);
    run("sb", 2'b11, 1'b0, 3'd0, 32'h202, 32'h000000AB,
        32'h0, 32'h0, 1, 0, 1'b0);
    run("sh_ovr", 2'b10, 1'b1, 3'd2, 32'h402, 32'h0000BEEF,
        32'h0, 32'h0, 0, 0, 1'b0);
    run("sw_mis", 2'b01, 1'b0, 3'd0, 32'h301, 32'h11223344,
        32'h0, 32'h0, 1, 2, 1'b0);
    run("lh_mis", 2'b00, 1'b1, 3'd1, 32'hFFFFFFFF, 32'h0,
        32'h8899AABB, 32'h11223380, 0, 1, 1'b0);
    run("noop", 2'b00, 1'b0, 3'd0, 32'h500, 32'h0,
        32'h12345678, 32'h0, 0, 0, 1'b0);
    run("tmo", 2'b00, 1'b1, 3'd0, 32'h600, 32'h0,
        32'h0, 32'h0, 0, 0, 1'b1);

    // reset while the first beat is outstanding
    req_valid = 1'b1;
    LoadOp    = 1'b1;
    MemWrite  = 2'b00;
    SizeLoad  = 3'd0;
    addr      = 32'h700;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid.bus_req_before", {31'h0, bus_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid.bus_req", {31'h0, bus_req}, 32'd0);
    chk("rstmid.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rstmid.req_ready", {31'h0, req_ready}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid.quiet_rsp", {31'h0, rsp_valid}, 32'd0);
      chk("rstmid.quiet_req", {31'h0, bus_req}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      run($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)),
          1'($urandom), 3'($urandom_range(0, 4)), $urandom, $urandom,
          $urandom, $urandom, $urandom_range(0, 3),
          $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
